dmaarb: RTL and testbench

//  DMA bus arbiter and address sequencer for the GSTMCU. It takes the 68000 bus on a

---
 rtl/dmaarb_if.sv | 29 ++
 rtl/dmaarb.sv | 111 +++++++++++
 tb/tb_dmaarb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmaarb_if.sv
// Bus-side signals of the DMA arbiter: 68000 handshake, slot strobe, address register
// writes and the DMA address/cycle outputs. The arbiter uses the slave modport.
interface dmaarb_if;
  logic        cyc_slot;
  logic        dreq;
  logic        bg_n;
  logic        as_n;
  logic        we_h;
  logic        we_m;
  logic        we_l;
  logic [7:0]  din;
  logic        br_n;
  logic        bgack_n;
  logic        ixdmab;
  logic [22:0] dma_addr;
  logic        dma_cyc;
  logic        dma_done;
  logic        busy;

  modport master (
    output cyc_slot, dreq, bg_n, as_n, we_h, we_m, we_l, din,
    input  br_n, bgack_n, ixdmab, dma_addr, dma_cyc, dma_done, busy
  );

  modport slave (
    input  cyc_slot, dreq, bg_n, as_n, we_h, we_m, we_l, din,
    output br_n, bgack_n, ixdmab, dma_addr, dma_cyc, dma_done, busy
  );
endinterface

// File: rtl/dmaarb.sv
// DMA bus arbiter: BR/BG/BGACK handshake, fixed word bursts on bus slots, and the
// FF8609/B/D word-address counter. All outputs registered; synchronous active-low reset.
module dmaarb #(
  parameter int BURST_WORDS = 8
) (
  input  logic     clk,
  input  logic     resb,
  dmaarb_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAITBUS, XFER, REL} state_t;

  localparam logic [7:0] LAST_WORD = 8'(BURST_WORDS - 1);

  state_t      state_q;
  logic        br_n_q;
  logic        bgack_n_q;
  logic        ixdmab_q;
  logic        cyc_q;
  logic        done_q;
  logic        busy_q;
  logic [7:0]  cnt_q;
  logic [22:0] addr_q;
  logic [22:0] addr_d;

  // Byte-register writes only land while idle; the counter advances on the edge that
  // ends each dma_cyc pulse so the address is stable for the whole pulse.
  always_comb begin
    addr_d = addr_q;
    if (state_q == IDLE) begin
      if (bus.we_h) addr_d[22:15] = bus.din;
      if (bus.we_m) addr_d[14:7]  = bus.din;
      if (bus.we_l) addr_d[6:0]   = bus.din[7:1];
    end else if (state_q == XFER && cyc_q) begin
      addr_d = addr_q + 23'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resb) begin
      state_q   <= IDLE;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      ixdmab_q  <= 1'b1;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 8'd0;
      addr_q    <= 23'd0;
    end else begin
      addr_q <= addr_d;
      cyc_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.dreq) begin
            state_q <= REQ;
            br_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (!bus.bg_n) begin
            state_q <= WAITBUS;
          end else if (!bus.dreq) begin
            state_q <= IDLE;
            br_n_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        WAITBUS: begin
          // Take the bus only once the current CPU cycle has finished.
          if (!bus.bg_n && bus.as_n) begin
            state_q   <= XFER;
            bgack_n_q <= 1'b0;
            br_n_q    <= 1'b1;
            ixdmab_q  <= 1'b0;
          end
        end
        XFER: begin
          if (cyc_q) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == LAST_WORD) begin
              state_q   <= REL;
              bgack_n_q <= 1'b1;
              ixdmab_q  <= 1'b1;
              done_q    <= 1'b1;
            end
          end else if (bus.cyc_slot) begin
            cyc_q <= 1'b1;
          end
        end
        REL: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.br_n     = br_n_q;
  assign bus.bgack_n  = bgack_n_q;
  assign bus.ixdmab   = ixdmab_q;
  assign bus.dma_addr = addr_q;
  assign bus.dma_cyc  = cyc_q;
  assign bus.dma_done = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dmaarb.sv
// Directed bench for dmaarb: table of single-cycle vectors plus hand-written burst
// sequences (full burst with busy write, address wrap, reset mid-burst).
module tb_dmaarb;

  logic clk;
  logic resb;
  int   checks;
  int   errors;

  dmaarb_if bus ();

  dmaarb #(.BURST_WORDS(8)) dut (
    .clk  (clk),
    .resb (resb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        resb;
    logic        dreq;
    logic        bg_n;
    logic        we_h;
    logic        we_m;
    logic        we_l;
    logic [7:0]  din;
    logic        e_br_n;
    logic        e_bgack_n;
    logic        e_ixdmab;
    logic        e_busy;
    logic [22:0] e_addr;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic write_addr(input logic [22:0] w);
    bus.we_h = 1'b1; bus.din = w[22:15]; tick();
    bus.we_h = 1'b0;
    bus.we_m = 1'b1; bus.din = w[14:7];  tick();
    bus.we_m = 1'b0;
    bus.we_l = 1'b1; bus.din = {w[6:0], 1'b1}; tick();
    bus.we_l = 1'b0;
    bus.din  = 8'h00;
  endtask

  // rst_after = 0 runs the burst to completion; otherwise reset after that many dma_cyc.
  task automatic burst(input logic [22:0] start, input bit busy_write, input int rst_after);
    int k = 0;
    int done = 0;
    bit wrote = 0;
    bit chk_write = 0;
    logic [22:0] exp_a;
    write_addr(start);
    chk("addr_load", {9'd0, bus.dma_addr}, {9'd0, start});
    bus.dreq = 1'b1; bus.bg_n = 1'b1; bus.as_n = 1'b1;
    tick();
    chk("br_asserted", {31'd0, bus.br_n}, 32'd0);
    chk("bgack_before_grant", {31'd0, bus.bgack_n}, 32'd1);
    for (int c = 0; c < 200; c++) begin
      bus.cyc_slot = (c % 4 == 0);
      bus.bg_n     = !(c >= 3 && k < 4);
      bus.we_l     = 1'b0;
      chk_write    = 1'b0;
      if (busy_write && k == 2 && !wrote) begin
        bus.we_l = 1'b1; bus.din = 8'hFE; wrote = 1'b1; chk_write = 1'b1;
      end
      tick();
      exp_a = start + 23'(k);
      if (chk_write) chk("busy_write_ignored", {9'd0, bus.dma_addr}, {9'd0, exp_a});
      if (bus.dma_cyc) begin
        chk("cyc_addr", {9'd0, bus.dma_addr}, {9'd0, exp_a});
        chk("cyc_ixdmab", {31'd0, bus.ixdmab}, 32'd0);
        chk("cyc_bgack", {31'd0, bus.bgack_n}, 32'd0);
        k++;
        bus.dreq = 1'b0;
        if (k == rst_after) break;
      end
      if (bus.dma_done) begin
        done++;
        chk("done_bgack", {31'd0, bus.bgack_n}, 32'd1);
        chk("done_ixdmab", {31'd0, bus.ixdmab}, 32'd1);
      end
      if (done > 0 && !bus.busy) break;
    end
    bus.cyc_slot = 1'b0; bus.we_l = 1'b0; bus.bg_n = 1'b1; bus.dreq = 1'b0;
    if (rst_after != 0) begin
      chk("rst_cyc_count", k, rst_after);
      resb = 1'b0;
      tick();
      chk("rst_ixdmab", {31'd0, bus.ixdmab}, 32'd1);
      chk("rst_bgack", {31'd0, bus.bgack_n}, 32'd1);
      chk("rst_br", {31'd0, bus.br_n}, 32'd1);
      chk("rst_addr", {9'd0, bus.dma_addr}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      resb = 1'b1;
      for (int c = 0; c < 12; c++) begin
        bus.cyc_slot = (c % 4 == 0);
        tick();
        if (bus.dma_done) done++;
      end
      bus.cyc_slot = 1'b0;
      chk("rst_no_done", done, 0);
    end else begin
      exp_a = start + 23'd8;
      chk("burst_words", k, 8);
      chk("burst_done_count", done, 1);
      chk("burst_end_addr", {9'd0, bus.dma_addr}, {9'd0, exp_a});
      chk("burst_end_bgack", {31'd0, bus.bgack_n}, 32'd1);
      chk("burst_end_br", {31'd0, bus.br_n}, 32'd1);
      chk("burst_end_busy", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resb = 1'b0;
    bus.cyc_slot = 1'b0; bus.dreq = 1'b0; bus.bg_n = 1'b1; bus.as_n = 1'b1;
    bus.we_h = 1'b0; bus.we_m = 1'b0; bus.we_l = 1'b0; bus.din = 8'h00;

    //          name        resb dreq bg_n we_h we_m we_l din    br  bgk ix  busy addr
    vecs[0]  = '{"rst0",      0, 0, 1, 0, 0, 0, 8'h00, 1, 1, 1, 0, 23'h000000};
    vecs[1]  = '{"rst1",      0, 0, 1, 0, 0, 0, 8'h00, 1, 1, 1, 0, 23'h000000};
    vecs[2]  = '{"wr_h",      1, 0, 1, 1, 0, 0, 8'h12, 1, 1, 1, 0, 23'h090000};
    vecs[3]  = '{"wr_m",      1, 0, 1, 0, 1, 0, 8'h34, 1, 1, 1, 0, 23'h091A00};
    vecs[4]  = '{"wr_l",      1, 0, 1, 0, 0, 1, 8'h57, 1, 1, 1, 0, 23'h091A2B};
    vecs[5]  = '{"wr_all_ff", 1, 0, 1, 1, 1, 1, 8'hFF, 1, 1, 1, 0, 23'h7FFFFF};
    vecs[6]  = '{"wr_all_00", 1, 0, 1, 1, 1, 1, 8'h00, 1, 1, 1, 0, 23'h000000};
    vecs[7]  = '{"req1",      1, 1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 23'h000000};
    vecs[8]  = '{"req2",      1, 1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 23'h000000};
    vecs[9]  = '{"withdraw",  1, 0, 1, 0, 0, 0, 8'h00, 1, 1, 1, 0, 23'h000000};
    vecs[10] = '{"idle",      1, 0, 1, 0, 0, 0, 8'h00, 1, 1, 1, 0, 23'h000000};

    for (int i = 0; i < 11; i++) begin
      resb     = vecs[i].resb;
      bus.dreq = vecs[i].dreq;
      bus.bg_n = vecs[i].bg_n;
      bus.we_h = vecs[i].we_h;
      bus.we_m = vecs[i].we_m;
      bus.we_l = vecs[i].we_l;
      bus.din  = vecs[i].din;
      tick();
      chk({vecs[i].nm, ".br_n"},    {31'd0, bus.br_n},    {31'd0, vecs[i].e_br_n});
      chk({vecs[i].nm, ".bgack_n"}, {31'd0, bus.bgack_n}, {31'd0, vecs[i].e_bgack_n});
      chk({vecs[i].nm, ".ixdmab"},  {31'd0, bus.ixdmab},  {31'd0, vecs[i].e_ixdmab});
      chk({vecs[i].nm, ".busy"},    {31'd0, bus.busy},    {31'd0, vecs[i].e_busy});
      chk({vecs[i].nm, ".addr"},    {9'd0, bus.dma_addr}, {9'd0, vecs[i].e_addr});
      chk({vecs[i].nm, ".cyc"},     {31'd0, bus.dma_cyc}, 32'd0);
      chk({vecs[i].nm, ".done"},    {31'd0, bus.dma_done}, 32'd0);
    end
    bus.we_h = 1'b0; bus.we_m = 1'b0; bus.we_l = 1'b0; bus.dreq = 1'b0;
    tick();

    burst(23'h001000, 1'b1, 0);
    tick();
    burst(23'h7FFFFE, 1'b0, 0);
    tick();
    burst(23'h002000, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
